cp0_reg: RTL and testbench
==========================

# cp0_reg

Coprocessor-0 register file for the MIPS32 core. It consumes the CP0 write channel that leaves the MEM/WB pipeline register (write enable, address, data) and the exception summary from the memory stage. It holds Count, Compare, Status, Cause, EPC, PRId and Config, and raises the timer interrupt. It provides a combinational read port to the execute stage; any MEM/WB-to-EX forwarding of CP0 values is done outside this block.

## Interface
- PRID_VALUE, 32'h00480102, read-only PRId contents
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we_i  in  1  CP0 write enable, from WB stage
- waddr_i  in  5  CP0 write address, from WB stage
- data_i  in  32  CP0 write data, from WB stage
- raddr_i  in  5  CP0 read address, from EX stage
- int_i  in  6  external hardware interrupt lines; bit 5 is normally `timer_int_o` fed back
- excepttype_i  in  32  exception code from MEM stage; 0 means no exception
- current_inst_addr_i  in  32  PC of the MEM-stage instruction
- is_in_delayslot_i  in  1  the MEM-stage instruction sits in a delay slot
- data_o  out  32  read data (combinational)
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  registered register contents
- timer_int_o  out  1  timer interrupt request

## Operation
- Register addresses:
  - Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14, PRId = 15, Config = 16.
  - Any other address: writes are ignored and reads return 0.
- Reset values:
  - Count 0, Compare 0, Status 32'h10000000 (CU0=1), Cause 0, EPC 0, Config 32'h00008000 (BE=1), timer_int_o 0.
  - prid_o always equals PRID_VALUE.
  - data_o is 0 while rst=1.
- Writes (we_i=1):
  - Count, Compare, Status and EPC take the full 32-bit value.
  - Cause writes only IP[1:0] (bits 9:8), WP (22) and IV (23). All other Cause bits are unaffected.
  - Writes to PRId and Config are ignored.
  - A Compare write also clears timer_int_o.
- Every cycle, Cause[15:10] <= int_i.
- Timer: when Compare != 0 and Count == Compare, timer_int_o <= 1. It stays set until the next Compare write or reset.
- Exceptions (excepttype_i != 0):
  - Interrupt (32'h1), syscall (32'h8), invalid instruction (32'ha), trap (32'hd), overflow (32'hc) set ExcCode (Cause[6:2]) to 0x00, 0x08, 0x0a, 0x0d, 0x0c respectively.
  - For these types, if Status.EXL (bit 1) is 0:
    - EPC <= current_inst_addr_i − 4 and Cause.BD (bit 31) <= 1 when is_in_delayslot_i=1.
    - Otherwise EPC <= current_inst_addr_i and BD <= 0.
  - For these types, if EXL is already 1, EPC and BD are unchanged.
  - Then Status.EXL <= 1.
  - eret (32'he): Status.EXL <= 0. EPC and Cause are untouched.
  - Any other nonzero code: no effect.
- Same-cycle priority:
  - An exception update overrides a WB write to the same field. For example, a Status write plus syscall leaves EXL=1; the other written Status bits still land.
  - A Count write overrides the increment.
  - A Compare write clears timer_int_o even if a match occurs that cycle.
- Read port: data_o = register selected by raddr_i, taken from current register state. There is no write-to-read bypass.

## Timing
- All registers update one cycle after their inputs are sampled; writes are visible on *_o and data_o the next cycle.
- Count increments by 1 every cycle after reset deasserts, wrapping 32'hFFFFFFFF -> 0.
- timer_int_o asserts on the cycle after Count == Compare is observed.
- Reset mid-operation restores all reset values on the next edge, overriding any write or exception.

## Configuration
- CP0_TIMER_EN defined:
  - Count free-runs as described.
  - The Compare match drives timer_int_o.
- CP0_TIMER_EN undefined:
  - Count changes only by software write and otherwise holds.
  - timer_int_o is constant 0.
  - Compare remains read/write storage.

## Test plan
- Reset then read: rst=1 for 2 cycles, release -> status_o=32'h10000000, config_o=32'h00008000, cause_o=0, prid_o=32'h00480102, count_o increments 1, 2, 3… (with CP0_TIMER_EN).
- Timer: write Count=0 and Compare=10 -> timer_int_o=1 exactly one cycle after count_o=10; then write Compare=100 -> timer_int_o=0 next cycle.
- Delay-slot syscall:
  - Stimulus: excepttype_i=32'h8, current_inst_addr_i=32'h00000120, is_in_delayslot_i=1, EXL=0.
  - Response: epc_o=32'h0000011c, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
  - Follow with an overflow while EXL=1: EPC unchanged, ExcCode=0x0c.
- eret: with EXL=1, excepttype_i=32'he -> status_o[1]=0, epc_o unchanged.
- Masked Cause write + collision:
  - Write Cause=32'hFFFFFFFF with int_i=6'b000101 -> cause_o=32'h00C01700.
  - Same-cycle Status write 32'h0 plus syscall -> status_o=32'h00000002.
- Count wrap: write Count=32'hFFFFFFFF -> count_o=0 the following cycle. Without CP0_TIMER_EN, count_o stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/cp0_reg_if.sv
// CP0 register file bus.
// Bundles the WB write channel, the EX read port, the MEM-stage exception
// summary, the interrupt lines and the register-content outputs.
//
// Handshake: there is no valid/ready pair. we_i qualifies waddr_i/data_i
// in the cycle it is high and always completes. raddr_i -> data_o is a pure
// combinational read. excepttype_i != 0 marks an exception in that cycle.
interface cp0_reg_if;
   // WB write channel
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   // EX read port
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   // Interrupts and MEM-stage exception summary
   logic [5:0]  int_i;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;
   // Register contents
   logic [31:0] count_o;
   logic [31:0] compare_o;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic [31:0] config_o;
   logic [31:0] prid_o;
   logic        timer_int_o;

   // Pipeline side
   modport master (
      output we_i, waddr_i, data_i, raddr_i, int_i,
             excepttype_i, current_inst_addr_i, is_in_delayslot_i,
      input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
             config_o, prid_o, timer_int_o
   );

   // CP0 register file side
   modport slave (
      input  we_i, waddr_i, data_i, raddr_i, int_i,
             excepttype_i, current_inst_addr_i, is_in_delayslot_i,
      output data_o, count_o, compare_o, status_o, cause_o, epc_o,
             config_o, prid_o, timer_int_o
   );
endinterface

// File: rtl/cp0_reg.sv
// MIPS32 coprocessor-0 register file: Count, Compare, Status, Cause, EPC,
// PRId, Config, plus the timer interrupt.
// Build option: CP0_TIMER_EN enables the free-running Count and the
// Compare-match timer interrupt; without it Count only changes by write and
// timer_int_o is tied low.
module cp0_reg #(
   parameter logic [31:0] PRID_VALUE = 32'h00480102
) (
   input  logic     clk,
   input  logic     rst,
   cp0_reg_if.slave bus
);

   localparam logic [4:0]  ADDR_COUNT   = 5'd9;
   localparam logic [4:0]  ADDR_COMPARE = 5'd11;
   localparam logic [4:0]  ADDR_STATUS  = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
   localparam logic [4:0]  ADDR_EPC     = 5'd14;
   localparam logic [4:0]  ADDR_PRID    = 5'd15;
   localparam logic [4:0]  ADDR_CONFIG  = 5'd16;

   localparam logic [31:0] STATUS_RESET = 32'h10000000;
   localparam logic [31:0] CONFIG_VALUE = 32'h00008000;

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [31:0] r_status;
   logic [31:0] r_cause;
   logic [31:0] r_epc;

   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic        w_exc_take;
   logic [4:0]  w_exc_code;
   logic        w_eret;
   logic [31:0] w_count_inc;
   logic [31:0] w_status_nxt;
   logic [31:0] w_cause_nxt;
   logic [31:0] w_epc_nxt;
   logic [31:0] w_rdata;

   // Decode which register the WB write targets (PRId/Config writes are dropped)
   always_comb begin
      w_wr_count   = bus.we_i && (bus.waddr_i == ADDR_COUNT);
      w_wr_compare = bus.we_i && (bus.waddr_i == ADDR_COMPARE);
      w_wr_status  = bus.we_i && (bus.waddr_i == ADDR_STATUS);
      w_wr_cause   = bus.we_i && (bus.waddr_i == ADDR_CAUSE);
      w_wr_epc     = bus.we_i && (bus.waddr_i == ADDR_EPC);
   end

   // Classify the MEM-stage exception: EPC-saving types vs eret vs ignored
   always_comb begin
      w_exc_take = 1'b0;
      w_exc_code = 5'h00;
      w_eret     = 1'b0;
      case (bus.excepttype_i)
         32'h00000001: begin w_exc_take = 1'b1; w_exc_code = 5'h00; end
         32'h00000008: begin w_exc_take = 1'b1; w_exc_code = 5'h08; end
         32'h0000000a: begin w_exc_take = 1'b1; w_exc_code = 5'h0a; end
         32'h0000000d: begin w_exc_take = 1'b1; w_exc_code = 5'h0d; end
         32'h0000000c: begin w_exc_take = 1'b1; w_exc_code = 5'h0c; end
         32'h0000000e: w_eret = 1'b1;
         default: ;
      endcase
   end

   // Count advance: free-running only when the timer is built in
   always_comb begin
`ifdef CP0_TIMER_EN
      w_count_inc = r_count + 32'd1;
`else
      w_count_inc = r_count;
`endif
   end

   // Next Status/Cause/EPC: software write first, exception update on top
   always_comb begin
      w_status_nxt = r_status;
      w_cause_nxt  = r_cause;
      w_epc_nxt    = r_epc;

      if (w_wr_status) w_status_nxt = bus.data_i;
      if (w_wr_epc)    w_epc_nxt    = bus.data_i;
      if (w_wr_cause) begin
         // Only IP[1:0], WP and IV are software-writable
         w_cause_nxt[9:8] = bus.data_i[9:8];
         w_cause_nxt[22]  = bus.data_i[22];
         w_cause_nxt[23]  = bus.data_i[23];
      end
      w_cause_nxt[15:10] = bus.int_i;

      if (w_exc_take) begin
         w_cause_nxt[6:2] = w_exc_code;
         // A nested exception (EXL already set) keeps the original EPC/BD
         if (!r_status[1]) begin
            w_cause_nxt[31] = bus.is_in_delayslot_i;
            w_epc_nxt = bus.is_in_delayslot_i ? (bus.current_inst_addr_i - 32'd4)
                                              : bus.current_inst_addr_i;
         end
         w_status_nxt[1] = 1'b1;
      end else if (w_eret) begin
         w_status_nxt[1] = 1'b0;
      end
   end

   // Register state update; reset overrides any write or exception
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= 32'd0;
         r_compare <= 32'd0;
         r_status  <= STATUS_RESET;
         r_cause   <= 32'd0;
         r_epc     <= 32'd0;
      end else begin
         r_count   <= w_wr_count ? bus.data_i : w_count_inc;
         if (w_wr_compare) r_compare <= bus.data_i;
         r_status  <= w_status_nxt;
         r_cause   <= w_cause_nxt;
         r_epc     <= w_epc_nxt;
      end
   end

`ifdef CP0_TIMER_EN
   logic r_timer_int;

   // Timer interrupt: set on Count==Compare (Compare!=0), held until a Compare write
   always_ff @(posedge clk) begin
      if (rst)
         r_timer_int <= 1'b0;
      else if (w_wr_compare)
         r_timer_int <= 1'b0;
      else if ((r_compare != 32'd0) && (r_count == r_compare))
         r_timer_int <= 1'b1;
   end

   assign bus.timer_int_o = r_timer_int;
`else
   assign bus.timer_int_o = 1'b0;
`endif

   // Combinational read port from current state; no write bypass
   always_comb begin
      w_rdata = 32'd0;
      if (!rst) begin
         case (bus.raddr_i)
            ADDR_COUNT:   w_rdata = r_count;
            ADDR_COMPARE: w_rdata = r_compare;
            ADDR_STATUS:  w_rdata = r_status;
            ADDR_CAUSE:   w_rdata = r_cause;
            ADDR_EPC:     w_rdata = r_epc;
            ADDR_PRID:    w_rdata = PRID_VALUE;
            ADDR_CONFIG:  w_rdata = CONFIG_VALUE;
            default:      w_rdata = 32'd0;
         endcase
      end
   end

   assign bus.data_o    = w_rdata;
   assign bus.count_o   = r_count;
   assign bus.compare_o = r_compare;
   assign bus.status_o  = r_status;
   assign bus.cause_o   = r_cause;
   assign bus.epc_o     = r_epc;
   assign bus.config_o  = CONFIG_VALUE;
   assign bus.prid_o    = PRID_VALUE;

endmodule

// File: tb/tb_cp0_reg.sv
// Testbench for cp0_reg: reset values, a table of directed write/exception
// vectors, then hand-written timer, Count wrap and mid-run reset sequences.
// Expectations for Count/timer follow CP0_TIMER_EN when defined.
module tb_cp0_reg;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   cp0_reg_if bus ();

   cp0_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [5:0]  intv;
      logic [31:0] exc;
      logic [31:0] pc;
      logic        ds;
      logic [4:0]  raddr;
      logic [31:0] e_status;
      logic [31:0] e_cause;
      logic [31:0] e_epc;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [15];

   // Clock: 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic [5:0] intv, input logic [31:0] exc,
                        input logic [31:0] pc, input logic ds, input logic [4:0] raddr);
      bus.we_i                = we;
      bus.waddr_i             = waddr;
      bus.data_i              = wdata;
      bus.int_i               = intv;
      bus.excepttype_i        = exc;
      bus.current_inst_addr_i = pc;
      bus.is_in_delayslot_i   = ds;
      bus.raddr_i             = raddr;
   endtask

   task automatic idle(input logic [4:0] raddr);
      drive(1'b0, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0, raddr);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //            we waddr  wdata          int        exc    pc     ds raddr  status         cause          epc            data
      vecs[0]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 6'b000101, 32'h0, 32'h0,   1'b0, 5'd13, 32'h10000000, 32'h00C01700, 32'h0,        32'h00C01700};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h0, 32'h0,   1'b0, 5'd13, 32'h10000000, 32'h00C00300, 32'h0,        32'h00C00300};
      vecs[2]  = '{1'b1, 5'd12, 32'h0,        6'b000000, 32'h8, 32'h200, 1'b0, 5'd12, 32'h00000002, 32'h00C00320, 32'h200,      32'h00000002};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'he, 32'h0,   1'b0, 5'd14, 32'h00000000, 32'h00C00320, 32'h200,      32'h200};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h8, 32'h120, 1'b1, 5'd14, 32'h00000002, 32'h80C00320, 32'h11c,      32'h11c};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'hc, 32'h500, 1'b0, 5'd13, 32'h00000002, 32'h80C00330, 32'h11c,      32'h80C00330};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h5, 32'h600, 1'b1, 5'd12, 32'h00000002, 32'h80C00330, 32'h11c,      32'h00000002};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'he, 32'h0,   1'b0, 5'd12, 32'h00000000, 32'h80C00330, 32'h11c,      32'h00000000};
      vecs[8]  = '{1'b1, 5'd14, 32'hDEADBEEF, 6'b000000, 32'h0, 32'h0,   1'b0, 5'd14, 32'h00000000, 32'h80C00330, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[9]  = '{1'b1, 5'd15, 32'h12345678, 6'b000000, 32'h0, 32'h0,   1'b0, 5'd15, 32'h00000000, 32'h80C00330, 32'hDEADBEEF, 32'h00480102};
      vecs[10] = '{1'b1, 5'd16, 32'h0,        6'b000000, 32'h0, 32'h0,   1'b0, 5'd16, 32'h00000000, 32'h80C00330, 32'hDEADBEEF, 32'h00008000};
      vecs[11] = '{1'b1, 5'd20, 32'h55,       6'b000000, 32'h0, 32'h0,   1'b0, 5'd20, 32'h00000000, 32'h80C00330, 32'hDEADBEEF, 32'h0};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        6'b100000, 32'h1, 32'h300, 1'b0, 5'd13, 32'h00000002, 32'h00C08300, 32'h300,      32'h00C08300};
      vecs[13] = '{1'b1, 5'd11, 32'h1234,     6'b000000, 32'h0, 32'h0,   1'b0, 5'd11, 32'h00000002, 32'h00C00300, 32'h300,      32'h1234};
      vecs[14] = '{1'b1, 5'd12, 32'hFF03,     6'b000000, 32'he, 32'h0,   1'b0, 5'd12, 32'h0000FF01, 32'h00C00300, 32'h300,      32'h0000FF01};

      // Reset: two cycles, read port must be 0 while reset is high
      rst = 1'b1;
      idle(5'd12);
      step();
      step();
      check("data_o_in_reset", bus.data_o, 32'h0);
      check("timer_in_reset", {31'd0, bus.timer_int_o}, 32'h0);

      // Release and watch Count
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
`ifdef CP0_TIMER_EN
         check("count_after_reset", bus.count_o, i);
`else
         check("count_after_reset", bus.count_o, 32'h0);
`endif
      end
      check("status_reset",  bus.status_o,  32'h10000000);
      check("config_reset",  bus.config_o,  32'h00008000);
      check("cause_reset",   bus.cause_o,   32'h0);
      check("epc_reset",     bus.epc_o,     32'h0);
      check("compare_reset", bus.compare_o, 32'h0);
      check("prid",          bus.prid_o,    32'h00480102);
      check("data_status",   bus.data_o,    32'h10000000);

      // Table-driven single-cycle vectors
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].intv,
               vecs[i].exc, vecs[i].pc, vecs[i].ds, vecs[i].raddr);
         step();
         check($sformatf("v%0d_status", i), bus.status_o, vecs[i].e_status);
         check($sformatf("v%0d_cause", i),  bus.cause_o,  vecs[i].e_cause);
         check($sformatf("v%0d_epc", i),    bus.epc_o,    vecs[i].e_epc);
         check($sformatf("v%0d_data", i),   bus.data_o,   vecs[i].e_data);
      end
      idle(5'd9);

`ifdef CP0_TIMER_EN
      // Timer: Compare=10, Count=0, interrupt one cycle after Count reads 10
      begin
         bit found;
         found = 1'b0;
         drive(1'b1, 5'd11, 32'd10, 6'd0, 32'h0, 32'h0, 1'b0, 5'd9);
         step();
         drive(1'b1, 5'd9, 32'd0, 6'd0, 32'h0, 32'h0, 1'b0, 5'd9);
         step();
         check("count_written_0", bus.count_o, 32'h0);
         check("timer_idle", {31'd0, bus.timer_int_o}, 32'h0);
         idle(5'd9);
         for (int i = 0; i < 20; i++) begin
            if (bus.count_o == 32'd10) begin
               found = 1'b1;
               break;
            end
            step();
         end
         check("count_reached_10", {31'd0, found}, 32'h1);
         check("timer_at_match", {31'd0, bus.timer_int_o}, 32'h0);
         step();
         check("timer_after_match", {31'd0, bus.timer_int_o}, 32'h1);
         step();
         check("timer_held", {31'd0, bus.timer_int_o}, 32'h1);
         drive(1'b1, 5'd11, 32'd100, 6'd0, 32'h0, 32'h0, 1'b0, 5'd11);
         step();
         check("timer_cleared", {31'd0, bus.timer_int_o}, 32'h0);
         check("compare_100", bus.data_o, 32'd100);
         idle(5'd9);
      end
`else
      // No timer: Count holds a written value, interrupt stays low
      drive(1'b1, 5'd9, 32'd5, 6'd0, 32'h0, 32'h0, 1'b0, 5'd9);
      step();
      idle(5'd9);
      for (int i = 0; i < 3; i++) begin
         check("count_holds", bus.count_o, 32'd5);
         step();
      end
      drive(1'b1, 5'd11, 32'd5, 6'd0, 32'h0, 32'h0, 1'b0, 5'd11);
      step();
      check("compare_rw", bus.data_o, 32'd5);
      idle(5'd9);
      step();
      step();
      check("timer_never", {31'd0, bus.timer_int_o}, 32'h0);
`endif

      // Count wrap
      drive(1'b1, 5'd9, 32'hFFFFFFFF, 6'd0, 32'h0, 32'h0, 1'b0, 5'd9);
      step();
      check("count_ffff", bus.count_o, 32'hFFFFFFFF);
      check("data_count", bus.data_o, 32'hFFFFFFFF);
      idle(5'd9);
      step();
`ifdef CP0_TIMER_EN
      check("count_wrap", bus.count_o, 32'h0);
`else
      check("count_wrap", bus.count_o, 32'hFFFFFFFF);
`endif

      // Reset mid-run overrides a same-cycle write and exception
      rst = 1'b1;
      drive(1'b1, 5'd12, 32'hFFFF, 6'b111111, 32'h8, 32'h400, 1'b1, 5'd12);
      step();
      check("rst_status", bus.status_o, 32'h10000000);
      check("rst_cause",  bus.cause_o,  32'h0);
      check("rst_epc",    bus.epc_o,    32'h0);
      check("rst_count",  bus.count_o,  32'h0);
      check("rst_data",   bus.data_o,   32'h0);
      rst = 1'b0;
      idle(5'd12);
      step();
      check("post_rst_data", bus.data_o, 32'h10000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
